// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the fixed sideband values used by the team's bus masters.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

endpackage

// File: rtl/ahb_master_wdog.sv
// Data-phase wait watchdog: counts consecutive stalled data-phase cycles and
// raises a sticky TIMEOUT once the count reaches MAX_WAIT.
module ahb_master_wdog #(
    parameter int MAX_WAIT = 16
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic d_valid,
    input  logic HREADY,
    output logic TIMEOUT
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (HREADY) begin
            r_cnt <= '0;
        end else if (d_valid) begin
            if (r_cnt != MAX_C) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Flag on the same edge the count lands on MAX_WAIT; the flag never self-clears.
            if (r_cnt >= MAX_C - 1'b1) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign TIMEOUT = r_timeout;

endmodule

// File: rtl/ahb_cmd_master.sv
// Single-transfer AHB-Lite initiator: valid/ready commands become pipelined NONSEQ
// word transfers, and every completed transfer returns one registered response.
module ahb_cmd_master
    import ahb_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [31:0] CMD_ADDR,
    input  logic [31:0] CMD_WDATA,
    output logic        RSP_VALID,
    output logic        RSP_WRITE,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        TIMEOUT,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);
    logic        r_a_valid;
    logic [31:0] r_a_addr;
    logic        r_a_write;
    logic [31:0] r_a_wdata;
    logic        r_d_valid;
    logic        r_d_write;
    logic [31:0] r_d_wdata;
    logic        r_rsp_valid;
    logic        r_rsp_write;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        w_accept;
    logic        w_complete;

    assign CMD_READY  = HREADY && !HRESET;
    assign w_accept   = CMD_VALID && CMD_READY;
    assign w_complete = r_d_valid && HREADY;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_a_valid   <= 1'b0;
            r_a_addr    <= '0;
            r_a_write   <= 1'b0;
            r_a_wdata   <= '0;
            r_d_valid   <= 1'b0;
            r_d_write   <= 1'b0;
            r_d_wdata   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            // A stalled bus freezes both stages, which keeps every bus output stable.
            if (HREADY) begin
                r_d_valid <= r_a_valid;
                r_d_write <= r_a_write;
                r_d_wdata <= r_a_wdata;
                r_a_valid <= w_accept;
                r_a_addr  <= w_accept ? CMD_ADDR  : '0;
                r_a_write <= w_accept ? CMD_WRITE : 1'b0;
                r_a_wdata <= w_accept ? CMD_WDATA : '0;
            end
            r_rsp_valid <= w_complete;
            r_rsp_write <= w_complete && r_d_write;
            r_rsp_err   <= w_complete && HRESP;
            r_rsp_rdata <= (w_complete && !r_d_write) ? HRDATA : '0;
        end
    end

    assign HTRANS = r_a_valid ? NONSEQ : IDLE;
    assign HADDR  = r_a_addr;
    assign HWRITE = r_a_write;
    assign HWDATA = (r_d_valid && r_d_write) ? r_d_wdata : '0;
    assign HSIZE  = HSIZE_WORD;
    assign HBURST = HBURST_SINGLE;
    assign HPROT  = HPROT_DATA;

    assign RSP_VALID = r_rsp_valid;
    assign RSP_WRITE = r_rsp_write;
    assign RSP_RDATA = r_rsp_rdata;
    assign RSP_ERR   = r_rsp_err;

    ahb_master_wdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wdog (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .d_valid (r_d_valid),
        .HREADY  (HREADY),
        .TIMEOUT (TIMEOUT)
    );

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Bench for ahb_cmd_master: directed cycle-exact scenarios plus a randomized run
// against a sequential-memory reference model and a behavioural AHB-Lite slave.
module tb_ahb_cmd_master;

    localparam int MW = 4;

    typedef struct packed {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic        w;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic        CMD_WRITE;
    logic [31:0] CMD_ADDR;
    logic [31:0] CMD_WDATA;
    logic        RSP_VALID;
    logic        RSP_WRITE;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic        TIMEOUT;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 HCLK = ~HCLK;

    ahb_cmd_master #(.MAX_WAIT(MW)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_WRITE (CMD_WRITE),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_WDATA (CMD_WDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_WRITE (RSP_WRITE),
        .RSP_RDATA (RSP_RDATA),
        .RSP_ERR   (RSP_ERR),
        .TIMEOUT   (TIMEOUT),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        CMD_VALID = 1'b0;
        CMD_WRITE = 1'b0;
        CMD_ADDR  = '0;
        CMD_WDATA = '0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = 32'hDEAD_0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        HRESET = 1'b1;
        tick();
        tick();
        HRESET = 1'b0;
        tick();
    endtask

    task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        CMD_VALID = 1'b1;
        CMD_WRITE = w;
        CMD_ADDR  = a;
        CMD_WDATA = d;
    endtask

    task automatic test_reset();
        idle_inputs();
        HRESET = 1'b1;
        #1;
        n_tests++;
        if (CMD_READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b exp 0", CMD_READY); end
        tick();
        n_tests++;
        if ({HTRANS, HADDR, HWRITE, HWDATA} !== 67'd0) begin
            n_fail++; $display("FAIL reset_bus: htrans=%b haddr=%h hwrite=%b hwdata=%h exp all 0", HTRANS, HADDR, HWRITE, HWDATA);
        end
        n_tests++;
        if ({RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_ERR, TIMEOUT} !== 36'd0) begin
            n_fail++; $display("FAIL reset_rsp: v=%b w=%b rd=%h e=%b to=%b exp all 0", RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_ERR, TIMEOUT);
        end
        n_tests++;
        if ({HSIZE, HBURST, HPROT} !== {3'b010, 3'b000, 4'b0011}) begin
            n_fail++; $display("FAIL sideband: hsize=%b hburst=%b hprot=%b exp 010 000 0011", HSIZE, HBURST, HPROT);
        end
        HRESET = 1'b0;
        #1;
        n_tests++;
        if (CMD_READY !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b exp 1", CMD_READY); end
        HREADY = 1'b0;
        #1;
        n_tests++;
        if (CMD_READY !== 1'b0) begin n_fail++; $display("FAIL ready_idle_stall: got %b exp 0", CMD_READY); end
        HREADY = 1'b1;
        tick();
    endtask

    task automatic test_write_zero_wait();
        do_reset();
        drive_cmd(1'b1, 32'h04, 32'h0001);
        tick();
        idle_inputs();
        n_tests++;
        if ({HTRANS, HADDR, HWRITE} !== {2'b10, 32'h04, 1'b1}) begin
            n_fail++; $display("FAIL wr_addr_phase: htrans=%b haddr=%h hwrite=%b exp 10 00000004 1", HTRANS, HADDR, HWRITE);
        end
        tick();
        n_tests++;
        if ({HTRANS, HWDATA, RSP_VALID} !== {2'b00, 32'h0001, 1'b0}) begin
            n_fail++; $display("FAIL wr_data_phase: htrans=%b hwdata=%h rsp_valid=%b exp 00 00000001 0", HTRANS, HWDATA, RSP_VALID);
        end
        tick();
        n_tests++;
        if ({RSP_VALID, RSP_WRITE, RSP_ERR, RSP_RDATA} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL wr_rsp: v=%b w=%b e=%b rd=%h exp 1 1 0 00000000", RSP_VALID, RSP_WRITE, RSP_ERR, RSP_RDATA);
        end
        tick();
        n_tests++;
        if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_pulse: got %b exp 0", RSP_VALID); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_cmd(1'b1, 32'h00, 32'h0000_A5A5);
        tick();
        drive_cmd(1'b0, 32'h00, 32'h0);
        n_tests++;
        if ({HTRANS, HADDR, HWRITE} !== {2'b10, 32'h0, 1'b1}) begin
            n_fail++; $display("FAIL b2b_wr_addr: htrans=%b haddr=%h hwrite=%b exp 10 00000000 1", HTRANS, HADDR, HWRITE);
        end
        tick();
        idle_inputs();
        n_tests++;
        if ({HTRANS, HADDR, HWRITE, HWDATA} !== {2'b10, 32'h0, 1'b0, 32'h0000_A5A5}) begin
            n_fail++; $display("FAIL b2b_overlap: htrans=%b haddr=%h hwrite=%b hwdata=%h exp 10 00000000 0 0000a5a5", HTRANS, HADDR, HWRITE, HWDATA);
        end
        tick();
        HRDATA = 32'h0000_A5A5;
        n_tests++;
        if ({RSP_VALID, RSP_WRITE, HWDATA} !== {1'b1, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL b2b_wr_rsp: v=%b w=%b hwdata=%h exp 1 1 00000000", RSP_VALID, RSP_WRITE, HWDATA);
        end
        tick();
        HRDATA = 32'hDEAD_0000;
        n_tests++;
        if ({RSP_VALID, RSP_WRITE, RSP_ERR, RSP_RDATA} !== {1'b1, 1'b0, 1'b0, 32'h0000_A5A5}) begin
            n_fail++; $display("FAIL b2b_rd_rsp: v=%b w=%b e=%b rd=%h exp 1 0 0 0000a5a5", RSP_VALID, RSP_WRITE, RSP_ERR, RSP_RDATA);
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        drive_cmd(1'b1, 32'h10, 32'h0000_1234);
        tick();
        drive_cmd(1'b0, 32'h20, 32'h0);
        tick();
        idle_inputs();
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if ({CMD_READY, HTRANS, HADDR, HWRITE, HWDATA, RSP_VALID} !== {1'b0, 2'b10, 32'h20, 1'b0, 32'h1234, 1'b0}) begin
                n_fail++; $display("FAIL wait_stable[%0d]: ready=%b htrans=%b haddr=%h hwrite=%b hwdata=%h rsp=%b exp 0 10 00000020 0 00001234 0",
                                   i, CMD_READY, HTRANS, HADDR, HWRITE, HWDATA, RSP_VALID);
            end
            tick();
        end
        HREADY = 1'b1;
        n_tests++;
        if ({HWDATA, RSP_VALID, TIMEOUT} !== {32'h1234, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL wait_release: hwdata=%h rsp=%b timeout=%b exp 00001234 0 0", HWDATA, RSP_VALID, TIMEOUT);
        end
        tick();
        HRDATA = 32'hCAFE_F00D;
        n_tests++;
        if ({RSP_VALID, RSP_WRITE, RSP_ERR} !== 3'b110) begin
            n_fail++; $display("FAIL wait_wr_rsp: v=%b w=%b e=%b exp 1 1 0", RSP_VALID, RSP_WRITE, RSP_ERR);
        end
        tick();
        HRDATA = 32'hDEAD_0000;
        n_tests++;
        if ({RSP_VALID, RSP_WRITE, RSP_RDATA} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
            n_fail++; $display("FAIL wait_rd_rsp: v=%b w=%b rd=%h exp 1 0 cafef00d", RSP_VALID, RSP_WRITE, RSP_RDATA);
        end
    endtask

    task automatic test_error();
        do_reset();
        drive_cmd(1'b1, 32'h08, 32'h0000_0BAD);
        tick();
        drive_cmd(1'b0, 32'h0C, 32'h0);
        tick();
        idle_inputs();
        HREADY = 1'b0;
        HRESP  = 1'b1;
        #1;
        n_tests++;
        if ({HTRANS, HADDR, HWRITE} !== {2'b10, 32'h0C, 1'b0}) begin
            n_fail++; $display("FAIL err_addr_kept: htrans=%b haddr=%h hwrite=%b exp 10 0000000c 0", HTRANS, HADDR, HWRITE);
        end
        tick();
        HREADY = 1'b1;
        tick();
        HRESP  = 1'b0;
        HRDATA = 32'h0000_55AA;
        n_tests++;
        if ({RSP_VALID, RSP_WRITE, RSP_ERR} !== 3'b111) begin
            n_fail++; $display("FAIL err_rsp: v=%b w=%b e=%b exp 1 1 1", RSP_VALID, RSP_WRITE, RSP_ERR);
        end
        tick();
        HRDATA = 32'hDEAD_0000;
        n_tests++;
        if ({RSP_VALID, RSP_WRITE, RSP_ERR, RSP_RDATA} !== {1'b1, 1'b0, 1'b0, 32'h55AA}) begin
            n_fail++; $display("FAIL err_next_rd: v=%b w=%b e=%b rd=%h exp 1 0 0 000055aa", RSP_VALID, RSP_WRITE, RSP_ERR, RSP_RDATA);
        end
    endtask

    task automatic test_random();
        logic [31:0] ref_mem [32];
        logic [31:0] slv_mem [32];
        cmd_t        q_cmd[$];
        rsp_t        q_rsp[$];
        cmd_t        sc;
        rsp_t        r;
        rsp_t        e;
        logic        s_active;
        logic        s_err;
        logic        s_err_first;
        int          s_wait;
        logic [4:0]  idx;
        do_reset();
        s_active = 1'b0; s_err = 1'b0; s_err_first = 1'b0; s_wait = 0; sc = '0;
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = $urandom;
            slv_mem[i] = ref_mem[i];
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (RSP_VALID === 1'b1) begin
                n_tests++;
                if (q_rsp.size() == 0) begin
                    n_fail++; $display("FAIL rand_rsp_extra: got w=%b e=%b rd=%h exp no response", RSP_WRITE, RSP_ERR, RSP_RDATA);
                end else begin
                    e = q_rsp.pop_front();
                    if ({RSP_WRITE, RSP_ERR, RSP_RDATA} !== {e.w, e.err, e.rdata}) begin
                        n_fail++; $display("FAIL rand_rsp: got w=%b e=%b rd=%h exp w=%b e=%b rd=%h",
                                           RSP_WRITE, RSP_ERR, RSP_RDATA, e.w, e.err, e.rdata);
                    end
                end
            end
            // Behavioural slave: optional OKAY waits, then a two-cycle ERROR for the top words.
            HRDATA = $urandom;
            HRESP  = 1'b0;
            if (!s_active) begin
                HREADY = ($urandom_range(0, 7) != 0);
            end else if (s_wait > 0) begin
                HREADY = 1'b0;
            end else if (s_err && s_err_first) begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end else begin
                HREADY = 1'b1;
                HRESP  = s_err;
                if (s_err) HRDATA = 32'h0;
                else if (!sc.w) HRDATA = slv_mem[sc.addr[6:2]];
            end
            CMD_VALID = (cyc < 560) && ($urandom_range(0, 3) != 0);
            CMD_WRITE = 1'($urandom_range(0, 1));
            CMD_ADDR  = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
            CMD_WDATA = $urandom;
            #1;
            n_tests++;
            if (CMD_READY !== HREADY) begin
                n_fail++; $display("FAIL rand_ready: got %b exp %b", CMD_READY, HREADY);
            end
            if (HREADY) begin
                if (s_active) begin
                    if (sc.w) begin
                        n_tests++;
                        if (HWDATA !== sc.wdata) begin
                            n_fail++; $display("FAIL rand_hwdata: got %h exp %h", HWDATA, sc.wdata);
                        end
                        if (!s_err) slv_mem[sc.addr[6:2]] = HWDATA;
                    end
                    s_active = 1'b0;
                end
                if (HTRANS === 2'b10) begin
                    n_tests++;
                    if (q_cmd.size() == 0) begin
                        n_fail++; $display("FAIL rand_addr_extra: got haddr=%h exp no transfer", HADDR);
                    end else begin
                        sc = q_cmd.pop_front();
                        if ({HADDR, HWRITE} !== {sc.addr, sc.w}) begin
                            n_fail++; $display("FAIL rand_addr: got haddr=%h hwrite=%b exp %h %b", HADDR, HWRITE, sc.addr, sc.w);
                        end
                        s_active    = 1'b1;
                        s_err       = (sc.addr[6:2] >= 5'd28);
                        s_err_first = 1'b1;
                        s_wait      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
                    end
                end
            end else if (s_active) begin
                if (s_wait > 0) s_wait--;
                else s_err_first = 1'b0;
            end
            // Reference: commands act on a plain memory in acceptance order.
            if (CMD_VALID && HREADY) begin
                q_cmd.push_back({CMD_WRITE, CMD_ADDR, CMD_WDATA});
                idx     = CMD_ADDR[6:2];
                r.w     = CMD_WRITE;
                r.err   = (idx >= 5'd28);
                r.rdata = 32'h0;
                if (!r.err) begin
                    if (CMD_WRITE) ref_mem[idx] = CMD_WDATA;
                    else r.rdata = ref_mem[idx];
                end
                q_rsp.push_back(r);
            end
            tick();
        end
        idle_inputs();
        n_tests++;
        if (q_rsp.size() != 0 || q_cmd.size() != 0) begin
            n_fail++; $display("FAIL rand_drain: got %0d responses and %0d transfers outstanding exp 0 0", q_rsp.size(), q_cmd.size());
        end
        n_tests++;
        if (TIMEOUT !== 1'b0) begin n_fail++; $display("FAIL rand_timeout: got %b exp 0", TIMEOUT); end
    endtask

    task automatic test_watchdog();
        do_reset();
        drive_cmd(1'b1, 32'h14, 32'h0000_7777);
        tick();
        idle_inputs();
        tick();
        HREADY = 1'b0;
        for (int i = 1; i <= MW; i++) begin
            tick();
            n_tests++;
            if (TIMEOUT !== (i == MW)) begin
                n_fail++; $display("FAIL wdog_wait%0d: got %b exp %b", i, TIMEOUT, (i == MW));
            end
        end
        tick();
        HREADY = 1'b1;
        tick();
        n_tests++;
        if ({RSP_VALID, RSP_WRITE, TIMEOUT} !== 3'b111) begin
            n_fail++; $display("FAIL wdog_sticky: rsp=%b w=%b timeout=%b exp 1 1 1", RSP_VALID, RSP_WRITE, TIMEOUT);
        end
        tick();
        tick();
        n_tests++;
        if (TIMEOUT !== 1'b1) begin n_fail++; $display("FAIL wdog_hold: got %b exp 1", TIMEOUT); end
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        n_tests++;
        if (TIMEOUT !== 1'b0) begin n_fail++; $display("FAIL wdog_clear: got %b exp 0", TIMEOUT); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_cmd(1'b1, 32'h40, 32'h0000_BEEF);
        tick();
        drive_cmd(1'b0, 32'h44, 32'h0);
        tick();
        idle_inputs();
        HRESET = 1'b1;
        #1;
        n_tests++;
        if (CMD_READY !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b exp 0", CMD_READY); end
        tick();
        n_tests++;
        if ({HTRANS, HADDR, HWDATA, RSP_VALID} !== 67'd0) begin
            n_fail++; $display("FAIL rstmid_bus: htrans=%b haddr=%h hwdata=%h rsp=%b exp all 0", HTRANS, HADDR, HWDATA, RSP_VALID);
        end
        tick();
        n_tests++;
        if ({CMD_READY, RSP_VALID} !== 2'b00) begin
            n_fail++; $display("FAIL rstmid_hold: ready=%b rsp=%b exp 0 0", CMD_READY, RSP_VALID);
        end
        HRESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if ({RSP_VALID, HTRANS} !== 3'b000) begin
                n_fail++; $display("FAIL rstmid_dropped[%0d]: rsp=%b htrans=%b exp 0 00", i, RSP_VALID, HTRANS);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL tb_timeout: got no finish exp finish before 200000ns");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        idle_inputs();
        HRESET = 1'b1;
        test_reset();
        test_write_zero_wait();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_random();
        test_watchdog();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
